dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single word-aligned data-memory port (10-bit word address, 32-bit data, 4-bit byte write enable) between two requesters.
- Requester 0 is the CPU load/store path, after byte/half lane steering. Requester 1 is the debug/program-loader DMA port.
- Grants one access per cycle using round-robin, with an anti-starvation override.
- Tags read returns through a latency pipeline so each requester receives only its own read data.

Parameters:
- ADDR_W, 10, word-address width.
- READ_LATENCY, 1, cycles from memory enable to valid mem_rdata; legal values 1..3.
- MAX_WAIT, 4, consecutive lost arbitration cycles after which the losing requester is force-granted; legal range 1..15.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- req0, in, 1, CPU request valid.
- we0, in, 4, CPU byte write enable; 0 means read.
- addr0, in, ADDR_W, CPU word address.
- wdata0, in, 32, CPU write data.
- gnt0, out, 1, CPU request accepted this cycle.
- rvalid0, out, 1, CPU read data valid.
- rdata0, out, 32, CPU read data.
- req1 / we1 / addr1 / wdata1 / gnt1 / rvalid1 / rdata1, same widths and meanings, for the DMA requester.
- mem_en, out, 1, memory access strobe.
- mem_we, out, 4, memory byte write enable.
- mem_addr, out, ADDR_W, memory word address.
- mem_wdata, out, 32, memory write data.
- mem_rdata, in, 32, memory read data, valid READ_LATENCY cycles after a read strobe.

Behaviour:
- Grant is combinational, in the same cycle as the request: at most one of gnt0/gnt1 is high; gntN is high only if reqN is high.
- Memory outputs mirror the granted requester's we/addr/wdata, with mem_en=1. With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Requesters hold req/we/addr/wdata stable until they see gnt. Dropping req before gnt is legal and causes no access.
- Arbitration, in priority order:
  1. Only one requester active: that requester wins.
  2. Both active and a starvation counter has reached MAX_WAIT: the starved requester wins.
  3. Otherwise round-robin: the requester not granted last wins.
- Round-robin state: last_grant register, reset value 1, so the CPU wins the first contended cycle. Updated only on cycles with a grant.
- Starvation counters wait0/wait1, 4 bits each, reset 0:
  - waitN increments when reqN=1 and gntN=0, saturating at MAX_WAIT.
  - waitN clears to 0 when gntN=1 or reqN=0.
  - Both counters at MAX_WAIT simultaneously is impossible under round-robin. If it occurs anyway, requester 0 wins.
- Read return pipeline: a READ_LATENCY-deep shift register of {valid, owner}. An entry is pushed on every granted read (mem_en=1, mem_we=0). Writes push valid=0.
- At the pipeline tail:
  - rvalidN=1 when valid=1 and owner=N.
  - rdataN = mem_rdata when rvalidN=1, else 0.
  - rvalid0 and rvalid1 are never both high.
- Back-to-back reads by either or alternating requesters are supported at full throughput: one grant per cycle, no bubbles.
- A write followed by a read to the same address on the next cycle returns the new data. No forwarding is needed, because the memory commits the write at the edge.
- Reset values: gnt0=gnt1=0 (combinational; requests are ignored while rst_n=0), rvalid0=rvalid1=0, rdata0=rdata1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pipeline cleared, last_grant=1, wait0=wait1=0.
- Reset asserted mid-operation: in-flight read tags are discarded and no rvalid is produced for them after reset release.

Test Plan:
- CPU-only read: req0=1, we0=0, addr0=0x010 → gnt0 same cycle, mem_en=1, mem_addr=0x010; with mem_rdata=0xDEADBEEF one cycle later → rvalid0=1, rdata0=0xDEADBEEF, rvalid1=0.
- Contention: req0=req1=1 for 4 cycles, both reads → grants alternate 0,1,0,1 after reset; rvalid owners follow the same order one cycle later.
- Starvation override: force last_grant so requester 1 loses, with a bench driving req0 each cycle only when requester 1 was granted previously (adversarial pattern), MAX_WAIT=2 → gnt1 asserted no later than the 3rd cycle of waiting; wait1 returns to 0.
- Byte write then read: req1, we1=4'b0100, addr1=0x3FF, wdata1=0x00AB0000 → mem_we=4'b0100, mem_addr=0x3FF; next-cycle read by requester 0 of 0x3FF is tagged to requester 0 only.
- READ_LATENCY=3, reads on 3 consecutive cycles (0,1,0) → rvalid0, rvalid1, rvalid0 on cycles +3, +4, +5 with matching data.
- Reset mid-flight: issue read, assert rst_n=0 for 1 cycle before return → no rvalid after release, all outputs 0, next contended grant goes to requester 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single word-aligned data-memory port.
// Round-robin grant with starvation override; read returns are tagged back to their owner.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_WAIT     = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0,
  input  logic [3:0]        we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [31:0]       rdata0,

  input  logic              req1,
  input  logic [3:0]        we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [31:0]       rdata1,

  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned PIPE_W = READ_LATENCY;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              last_grant;
  logic [WAIT_W-1:0] wait0;
  logic [WAIT_W-1:0] wait1;
  logic [PIPE_W-1:0] pipe_valid;
  logic [PIPE_W-1:0] pipe_owner;
  logic              push_read;
  logic              tail_valid;
  logic              tail_owner;

  function automatic logic [WAIT_W-1:0] next_wait(input logic req, input logic gnt,
                                                  input logic [WAIT_W-1:0] cnt);
    if (!req || gnt) return '0;
    if (cnt >= WAIT_MAX) return WAIT_MAX;
    return cnt + WAIT_W'(1);
  endfunction

  // Same-cycle grant; requests are ignored while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (wait0 >= WAIT_MAX) begin
          gnt0 = 1'b1;
        end else if (wait1 >= WAIT_MAX) begin
          gnt1 = 1'b1;
        end else if (last_grant) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
    end
  end

  // Memory port mirrors the winner and is fully zeroed when idle.
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign push_read = mem_en && (mem_we == 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      wait0      <= '0;
      wait1      <= '0;
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      if (mem_en) begin
        last_grant <= gnt1;
      end
      wait0      <= next_wait(req0, gnt0, wait0);
      wait1      <= next_wait(req1, gnt1, wait1);
      pipe_valid <= (pipe_valid << 1) | PIPE_W'(push_read);
      pipe_owner <= (pipe_owner << 1) | PIPE_W'(gnt1);
    end
  end

  // Tail of the tag pipeline lines up with mem_rdata for the owning requester.
  assign tail_valid = pipe_valid[PIPE_W-1];
  assign tail_owner = pipe_owner[PIPE_W-1];
  assign rvalid0    = tail_valid && !tail_owner;
  assign rvalid1    = tail_valid && tail_owner;
  assign rdata0     = rvalid0 ? mem_rdata : 32'h0;
  assign rdata1     = rvalid1 ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: latency-3 memory device, behavioural reference model
// checked every cycle, directed literal scenarios, then randomized traffic.
module tb_dmem_port_arbiter;

  localparam int ADDR_W   = 10;
  localparam int LAT      = 3;
  localparam int MAX_WAIT = 2;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1;
  logic [3:0]        we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0]       rdata0, rdata1;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .READ_LATENCY(LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    case (a)
      'h010:   return 32'hDEADBEEF;
      'h020:   return 32'hA0000020;
      'h021:   return 32'hB0000021;
      'h022:   return 32'hA0000022;
      'h040:   return 32'hC0DE0040;
      'h041:   return 32'hC0DE0041;
      'h050:   return 32'hC0DE0050;
      'h051:   return 32'hC0DE0051;
      'h3FF:   return 32'h11223344;
      default: return 32'(a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endcase
  endfunction

  // Memory device: access captured at the falling edge, committed at the rising edge.
  logic              acc_en = 1'b0;
  logic [3:0]        acc_we = 4'h0;
  logic [ADDR_W-1:0] acc_addr = '0;
  logic [31:0]       acc_wdata = 32'h0;
  logic [31:0]       mem_arr [DEPTH];
  logic [31:0]       rd_line [LAT];
  logic              dev_ready = 1'b0;

  assign mem_rdata = rd_line[LAT-1];

  always @(posedge clk) begin
    if (!dev_ready) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_word(i);
      for (int i = 0; i < LAT; i++) rd_line[i] <= $urandom;
      dev_ready <= 1'b1;
    end else begin
      for (int i = LAT - 1; i > 0; i--) rd_line[i] <= rd_line[i-1];
      if (acc_en && acc_we == 4'h0) rd_line[0] <= mem_arr[acc_addr];
      else                          rd_line[0] <= $urandom;
      if (acc_en)
        for (int b = 0; b < 4; b++)
          if (acc_we[b]) mem_arr[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
    end
  end

  // Reference model state
  typedef struct {
    int          due;
    logic        owner;
    logic [31:0] data;
  } ret_t;

  ret_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          m_last = 1, m_w0 = 0, m_w1 = 0;
  logic        g0_prev = 1'b0, g1_prev = 1'b0;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Predict this cycle's outputs from the arbitration rules, compare, then advance.
  task automatic model_step();
    logic              e0, e1, ev0, ev1;
    logic [3:0]        ewe;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       ewd, ed0, ed1;
    ret_t              r;
    cyc++;
    acc_en = mem_en; acc_we = mem_we; acc_addr = mem_addr; acc_wdata = mem_wdata;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst_n) begin
      m_last = 1; m_w0 = 0; m_w1 = 0;
      exp_q.delete();
    end else if (req0 && req1) begin
      if (m_w0 >= MAX_WAIT)      e0 = 1'b1;
      else if (m_w1 >= MAX_WAIT) e1 = 1'b1;
      else if (m_last == 1)      e0 = 1'b1;
      else                       e1 = 1'b1;
    end else begin
      e0 = req0;
      e1 = req1;
    end
    ewe = e0 ? we0    : (e1 ? we1    : 4'h0);
    ea  = e0 ? addr0  : (e1 ? addr1  : '0);
    ewd = e0 ? wdata0 : (e1 ? wdata1 : 32'h0);
    ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      if (r.owner) begin ev1 = 1'b1; ed1 = r.data; end
      else         begin ev0 = 1'b1; ed0 = r.data; end
    end
    check("grant_mem", {gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata},
          {e0, e1, e0 | e1, ewe, ea, ewd});
    check("read_return", {rvalid0, rvalid1, rdata0, rdata1}, {ev0, ev1, ed0, ed1});
    if (e0 || e1) begin
      if (ewe == 4'h0) begin
        r.due = cyc + LAT; r.owner = e1; r.data = ref_mem[ea];
        exp_q.push_back(r);
      end else begin
        for (int b = 0; b < 4; b++) if (ewe[b]) ref_mem[ea][8*b +: 8] = ewd[8*b +: 8];
      end
      m_last = e1 ? 1 : 0;
    end
    if (rst_n) begin
      m_w0 = (req0 && !e0) ? ((m_w0 + 1 > MAX_WAIT) ? MAX_WAIT : m_w0 + 1) : 0;
      m_w1 = (req1 && !e1) ? ((m_w1 + 1 > MAX_WAIT) ? MAX_WAIT : m_w1 + 1) : 0;
    end
    g0_prev = e0;
    g1_prev = e1;
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0;
    we0 = 4'h0; we1 = 4'h0; addr0 = '0; addr1 = '0; wdata0 = 32'h0; wdata1 = 32'h0;
  endtask

  task automatic new0(input logic r);
    req0   = r;
    we0    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    addr0  = ($urandom_range(0, 9) < 7) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom);
    wdata0 = $urandom;
  endtask

  task automatic new1(input logic r);
    req1   = r;
    we1    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    addr1  = ($urandom_range(0, 9) < 7) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom);
    wdata1 = $urandom;
  endtask

  // Requesters hold until granted, may abandon; adversarial mode lets CPU in only after DMA wins.
  task automatic drive_rand(input logic adv);
    if (g0_prev) req0 = 1'b0;
    if (g1_prev) req1 = 1'b0;
    if (!adv && req0 && $urandom_range(0, 15) == 0) req0 = 1'b0;
    if (!adv && req1 && $urandom_range(0, 15) == 0) req1 = 1'b0;
    if (!req0) new0(adv ? g1_prev : ($urandom_range(0, 99) < 60));
    if (!req1) new1(adv || ($urandom_range(0, 99) < 50));
    rst_n = ($urandom_range(0, 399) != 0);
  endtask

  logic [31:0] exp_data [4];
  logic        exp_own  [4];
  int          n0, n1;

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Reset: a pending request must be ignored and every output held at zero.
    req0 = 1'b1; addr0 = 10'h010;
    repeat (3) begin cyc_start(); sample(); end
    check("rst_gnt", {gnt0, gnt1, mem_en}, 3'b000);
    check("rst_mem", {mem_we, mem_addr, mem_wdata}, 46'h0);
    check("rst_ret", {rvalid0, rvalid1, rdata0, rdata1}, 66'h0);
    cyc_start(); idle(); rst_n = 1'b1; sample();

    // CPU-only read of 0x010
    cyc_start(); req0 = 1'b1; we0 = 4'h0; addr0 = 10'h010; sample();
    check("cpu_rd_gnt", {gnt0, gnt1, mem_en, mem_addr}, {1'b1, 1'b0, 1'b1, 10'h010});
    for (int k = 1; k <= LAT; k++) begin
      cyc_start(); idle(); sample();
      if (k == LAT) check("cpu_rd_ret", {rvalid0, rvalid1, rdata0}, {1'b1, 1'b0, 32'hDEADBEEF});
      else          check("cpu_rd_early", {rvalid0, rvalid1}, 2'b00);
    end

    // Contention straight after reset: 0,1,0,1 and returns in the same order
    cyc_start(); rst_n = 1'b0; sample();
    cyc_start(); rst_n = 1'b1; sample();
    exp_own  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{32'hC0DE0040, 32'hC0DE0050, 32'hC0DE0041, 32'hC0DE0051};
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4 + LAT; i++) begin
      cyc_start();
      idle();
      if (i < 4) begin
        req0 = 1'b1; addr0 = 10'h040 + 10'(n0);
        req1 = 1'b1; addr1 = 10'h050 + 10'(n1);
      end
      sample();
      if (i < 4) begin
        check("rr_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
        if (g0_prev) n0++;
        if (g1_prev) n1++;
      end
      if (i >= LAT)
        check("rr_ret", {rvalid0, rvalid1, rdata0, rdata1},
              {!exp_own[i-LAT], exp_own[i-LAT],
               exp_own[i-LAT] ? 32'h0 : exp_data[i-LAT], exp_own[i-LAT] ? exp_data[i-LAT] : 32'h0});
    end

    // Byte-lane write by DMA, then CPU reads the same word next cycle
    cyc_start(); idle(); req1 = 1'b1; we1 = 4'b0100; addr1 = 10'h3FF; wdata1 = 32'h00AB0000; sample();
    check("bw_mem", {gnt1, mem_en, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b1, 4'b0100, 10'h3FF, 32'h00AB0000});
    cyc_start(); idle(); req0 = 1'b1; addr0 = 10'h3FF; sample();
    check("bw_rd_gnt", {gnt0, gnt1, mem_addr}, {1'b1, 1'b0, 10'h3FF});
    for (int k = 1; k <= LAT; k++) begin
      cyc_start(); idle(); sample();
      if (k == LAT)
        check("bw_ret", {rvalid0, rvalid1, rdata0, rdata1}, {1'b1, 1'b0, 32'h11AB3344, 32'h0});
    end

    // Back-to-back reads 0,1,0 at full rate
    exp_own  = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_data = '{32'hA0000020, 32'hB0000021, 32'hA0000022, 32'h0};
    for (int i = 0; i < 3 + LAT; i++) begin
      cyc_start();
      idle();
      if (i == 0) begin req0 = 1'b1; addr0 = 10'h020; end
      if (i == 1) begin req1 = 1'b1; addr1 = 10'h021; end
      if (i == 2) begin req0 = 1'b1; addr0 = 10'h022; end
      sample();
      if (i < 3) check("b2b_gnt", {gnt0, gnt1}, (i == 1) ? 2'b01 : 2'b10);
      if (i >= LAT)
        check("b2b_ret", {rvalid0, rvalid1, rdata0, rdata1},
              {!exp_own[i-LAT], exp_own[i-LAT],
               exp_own[i-LAT] ? 32'h0 : exp_data[i-LAT], exp_own[i-LAT] ? exp_data[i-LAT] : 32'h0});
    end

    // Reset while a read is in flight
    cyc_start(); idle(); req0 = 1'b1; addr0 = 10'h010; sample();
    check("mid_rd_gnt", {gnt0, gnt1}, 2'b10);
    cyc_start(); idle(); rst_n = 1'b0; sample();
    check("mid_rst_out", {gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata, rvalid0, rvalid1, rdata0, rdata1},
          115'h0);
    cyc_start(); rst_n = 1'b1; sample();
    for (int k = 0; k < LAT + 1; k++) begin
      cyc_start(); sample();
      check("mid_rst_ret", {rvalid0, rvalid1}, 2'b00);
    end
    cyc_start(); req0 = 1'b1; addr0 = 10'h001; req1 = 1'b1; addr1 = 10'h002; sample();
    check("mid_rst_rr", {gnt0, gnt1}, 2'b10);
    cyc_start(); idle(); sample();

    // Randomized traffic, then adversarial CPU pattern against a busy DMA
    for (int i = 0; i < 3000; i++) begin cyc_start(); drive_rand(1'b0); sample(); end
    for (int i = 0; i < 600; i++)  begin cyc_start(); drive_rand(1'b1); sample(); end
    cyc_start(); idle(); rst_n = 1'b1; sample();
    repeat (LAT + 2) begin cyc_start(); sample(); end
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
